// File: rtl/se_pkg.sv
// ============================================================================
//  se_pkg
//  Shared widths, FSM state type, note record and the built-in effect scores.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package se_pkg;

  localparam int SE_NUM_EFFECTS = 4;
  localparam int SE_MAX_NOTES   = 16;
  localparam int SE_FREQ_W      = 16;
  localparam int SE_DUR_W       = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } se_state_t;

  typedef struct packed {
    logic [SE_FREQ_W-1:0] freq;
    logic [SE_DUR_W-1:0]  duration;
    logic                 last;
  } se_note_t;

  // Effect 0: two-tone chirp.
  localparam se_note_t SE_FX0 [2] = '{
    '{16'd1000, 32'd4, 1'b0},
    '{16'd1300, 32'd4, 1'b1}
  };

  // Effect 1: tone, rest, tone.
  localparam se_note_t SE_FX1 [3] = '{
    '{16'd500, 32'd2, 1'b0},
    '{16'd0,   32'd3, 1'b0},
    '{16'd700, 32'd2, 1'b1}
  };

  // Effect 2 is an unterminated ramp; it runs until the note index limit.
  localparam int SE_FX2_LEN = 16;

  function automatic se_note_t se_fx2_note(input int idx);
    se_note_t n;
    n.freq     = SE_FREQ_W'(100 * (idx + 1));
    n.duration = (idx == 0) ? SE_DUR_W'(0) : ((idx == 1) ? SE_DUR_W'(2) : SE_DUR_W'(1));
    n.last     = 1'b0;
    return n;
  endfunction

  // Effect 3: long alert with a short gap.
  localparam se_note_t SE_FX3 [3] = '{
    '{16'd440, 32'd8, 1'b0},
    '{16'd0,   32'd2, 1'b0},
    '{16'd880, 32'd8, 1'b1}
  };

endpackage

`default_nettype wire

// File: rtl/se_score_rom.sv
// ============================================================================
//  se_score_rom
//  Combinational (effect, note index) -> note record lookup.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module se_score_rom
  import se_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int IDX_W = 4
) (
  input  logic [SEL_W-1:0] effect,
  input  logic [IDX_W-1:0] index,
  output se_note_t         note
);

  // Out-of-table reads give a one-cycle terminating rest.
  localparam se_note_t c_pad = '{freq: '0, duration: SE_DUR_W'(1), last: 1'b1};

  int w_fx;
  int w_ix;

  assign w_fx = int'(effect);
  assign w_ix = int'(index);

  always_comb begin
    note = c_pad;
    case (w_fx)
      0: for (int i = 0; i < 2; i++) if (w_ix == i) note = SE_FX0[i];
      1: for (int i = 0; i < 3; i++) if (w_ix == i) note = SE_FX1[i];
      2: if (w_ix < SE_FX2_LEN) note = se_fx2_note(w_ix);
      3: for (int i = 0; i < 3; i++) if (w_ix == i) note = SE_FX3[i];
      default: note = c_pad;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/se_sequencer.sv
// ============================================================================
//  se_sequencer
//  Sound-effect note sequencer with registered tone outputs.
//  Optional feature macro: SE_SEQ_LOOP_EN (adds iLoop, repeat-until-stop).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module se_sequencer
  import se_pkg::*;
#(
  parameter int NUM_EFFECTS = SE_NUM_EFFECTS,
  parameter int MAX_NOTES   = SE_MAX_NOTES,
  parameter int FREQ_W      = SE_FREQ_W,
  parameter int DUR_W       = SE_DUR_W,
  localparam int SEL_W = (NUM_EFFECTS > 1) ? $clog2(NUM_EFFECTS) : 1,
  localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iTrig,
  input  logic [SEL_W-1:0]  iSel,
  input  logic              iStop,
`ifdef SE_SEQ_LOOP_EN
  input  logic              iLoop,
`endif
  output logic              oEnable,
  output logic [FREQ_W-1:0] oFreq,
  output logic              oBusy,
  output logic              oDone,
  output logic [IDX_W-1:0]  oNote
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(MAX_NOTES - 1);

  se_state_t         r_state, w_state;
  logic [SEL_W-1:0]  r_sel, w_sel, w_sel_clamped;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [DUR_W-1:0]  r_timer, w_timer, r_dur, w_dur_eff;
  logic              r_last;
  logic              w_done, w_expire, w_abort, w_start, w_loop_on, w_tone;
  logic [FREQ_W-1:0] w_freq;
  se_note_t          w_note;

`ifdef SE_SEQ_LOOP_EN
  logic r_loop;
  assign w_loop_on = r_loop;
`else
  assign w_loop_on = 1'b0;
`endif

  assign w_sel_clamped = (int'(iSel) >= NUM_EFFECTS) ? '0 : iSel;
  assign w_dur_eff     = (r_dur == '0) ? DUR_W'(1) : r_dur;
  assign w_expire      = (r_timer >= w_dur_eff - DUR_W'(1));
  assign w_abort       = (r_state == PLAY) && iStop;
  assign w_start       = !w_abort && iTrig;

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_idx   = r_idx;
    w_timer = r_timer;
    w_done  = 1'b0;
    if (w_abort) begin
      w_state = IDLE;
      w_idx   = '0;
      w_timer = '0;
    end else if (w_start) begin
      w_state = PLAY;
      w_sel   = w_sel_clamped;
      w_idx   = '0;
      w_timer = '0;
    end else if (r_state == PLAY) begin
      if (w_expire) begin
        w_timer = '0;
        if (r_last || (r_idx == c_last_idx)) begin
          w_idx = '0;
          if (!w_loop_on) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end
        end else begin
          w_idx = r_idx + 1'b1;
        end
      end else begin
        w_timer = r_timer + 1'b1;
      end
    end
  end

  // Look up the note about to be entered so the outputs can be registered.
  se_score_rom #(
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .effect (w_sel),
    .index  (w_idx),
    .note   (w_note)
  );

  assign w_freq = FREQ_W'(w_note.freq);
  assign w_tone = (w_state == PLAY) && (w_freq != '0);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_dur   <= '0;
      r_last  <= 1'b0;
`ifdef SE_SEQ_LOOP_EN
      r_loop  <= 1'b0;
`endif
      oEnable <= 1'b0;
      oFreq   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oNote   <= '0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_idx   <= w_idx;
      r_timer <= w_timer;
      r_dur   <= DUR_W'(w_note.duration);
      r_last  <= w_note.last;
`ifdef SE_SEQ_LOOP_EN
      if (w_start) r_loop <= iLoop;
`endif
      oEnable <= w_tone;
      oFreq   <= w_tone ? w_freq : '0;
      oBusy   <= (w_state == PLAY);
      oDone   <= w_done;
      oNote   <= w_idx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_se_sequencer.sv
// ============================================================================
//  tb_se_sequencer
//  Scoreboard bench: expected per-cycle outputs queued with each stimulus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_se_sequencer;

  logic       iClock;
  logic       iReset;
  logic       iTrig;
  logic [1:0] iSel;
  logic       iStop;
`ifdef SE_SEQ_LOOP_EN
  logic       iLoop;
`endif
  logic        oEnable;
  logic [15:0] oFreq;
  logic        oBusy;
  logic        oDone;
  logic [3:0]  oNote;

  typedef struct packed {
    logic        en;
    logic [15:0] freq;
    logic        busy;
    logic        done;
    logic [3:0]  note;
  } obs_t;

  obs_t w_obs;
  obs_t exp_q[$];
  obs_t e;
  int   total;
  int   bad;

  assign w_obs = '{en: oEnable, freq: oFreq, busy: oBusy, done: oDone, note: oNote};

  // Three effects so that iSel=3 exercises the out-of-range clamp.
  se_sequencer #(
    .NUM_EFFECTS (3),
    .MAX_NOTES   (16),
    .FREQ_W      (16),
    .DUR_W       (32)
  ) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iTrig   (iTrig),
    .iSel    (iSel),
    .iStop   (iStop),
`ifdef SE_SEQ_LOOP_EN
    .iLoop   (iLoop),
`endif
    .oEnable (oEnable),
    .oFreq   (oFreq),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oNote   (oNote)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  function automatic void push_note(input int freq, input int note, input int cycles);
    for (int i = 0; i < cycles; i++)
      exp_q.push_back('{en: (freq != 0), freq: 16'(freq), busy: 1'b1, done: 1'b0, note: 4'(note)});
  endfunction

  function automatic void push_idle(input logic done, input int cycles);
    for (int i = 0; i < cycles; i++)
      exp_q.push_back('{en: 1'b0, freq: 16'd0, busy: 1'b0, done: done, note: 4'd0});
  endfunction

  function automatic void push_fx0();
    push_note(1000, 0, 4);
    push_note(1300, 1, 4);
    push_idle(1'b1, 1);
    push_idle(1'b0, 1);
  endfunction

  function automatic void push_fx2();
    for (int i = 0; i < 16; i++) push_note(100 * (i + 1), i, (i == 1) ? 2 : 1);
    push_idle(1'b1, 1);
    push_idle(1'b0, 1);
  endfunction

  task automatic trig(input logic [1:0] sel);
    iTrig = 1'b1;
    iSel  = sel;
    @(posedge iClock); #1;
    iTrig = 1'b0;
    iSel  = 2'd0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    iTrig  = 1'b1;
    iStop  = 1'b1;
    push_idle(1'b0, 2);
    repeat (2) @(posedge iClock); #1;
    iTrig = 1'b0;
    iStop = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL reset: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                 w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
      end
      if (exp_q.size() != 0) begin
        iReset = 1'b0;
        @(posedge iClock); #1;
      end
    end
    iReset = 1'b0;
  endtask

  task automatic test_effect0();
    push_fx0();
    trig(2'd0);
    for (int c = 1; exp_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL effect0 cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                 c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
      end
      if (exp_q.size() != 0) begin @(posedge iClock); #1; end
    end
  endtask

  task automatic test_clamp_and_index_limit();
    push_fx0();
    trig(2'd3);
    for (int c = 1; exp_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL clamp cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                 c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
      end
      if (exp_q.size() != 0) begin @(posedge iClock); #1; end
    end
    push_fx2();
    trig(2'd2);
    for (int c = 1; exp_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e) begin
        bad++;
        $display("FAIL index_limit cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                 c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
      end
      if (exp_q.size() != 0) begin @(posedge iClock); #1; end
    end
  endtask

  task automatic test_rest_and_retrigger();
    push_note(1000, 0, 4);
    push_note(1300, 1, 1);
    trig(2'd0);
    // Second phase starts from the cycle-5 sample, when note 1 has just begun.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 1; exp_q.size() != 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL retrig_rest ph%0d cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                   phase, c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
        end
        if (exp_q.size() != 0) begin @(posedge iClock); #1; end
      end
      if (phase == 0) begin
        push_note(500, 0, 2);
        push_note(0, 1, 3);
        push_note(700, 2, 2);
        push_idle(1'b1, 1);
        push_idle(1'b0, 1);
        trig(2'd1);
      end
    end
  endtask

  task automatic test_trig_on_expiry();
    push_note(1000, 0, 4);
    trig(2'd0);
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 1; exp_q.size() != 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL trig_expiry ph%0d cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                   phase, c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
        end
        if (exp_q.size() != 0) begin @(posedge iClock); #1; end
      end
      if (phase == 0) begin
        push_fx2();
        trig(2'd2);
      end
    end
  endtask

  task automatic test_stop_with_trig();
    push_note(1000, 0, 2);
    trig(2'd0);
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 1; exp_q.size() != 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL stop_trig ph%0d cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                   phase, c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
        end
        if (exp_q.size() != 0) begin @(posedge iClock); #1; end
      end
      if (phase == 0) begin
        push_idle(1'b0, 12);
        iStop = 1'b1;
        trig(2'd1);
        iStop = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_note();
    push_note(1000, 0, 4);
    push_note(1300, 1, 2);
    trig(2'd0);
    for (int phase = 0; phase < 3; phase++) begin
      for (int c = 1; exp_q.size() != 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL reset_mid ph%0d cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                   phase, c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
        end
        if (exp_q.size() != 0) begin @(posedge iClock); #1; end
      end
      if (phase == 0) begin
        push_idle(1'b0, 10);
        iReset = 1'b1;
        @(posedge iClock); #1;
        iReset = 1'b0;
      end else if (phase == 1) begin
        push_fx0();
        trig(2'd0);
      end
    end
  endtask

`ifdef SE_SEQ_LOOP_EN
  task automatic test_loop();
    for (int l = 0; l < 3; l++) begin
      push_note(1000, 0, 4);
      push_note(1300, 1, 4);
    end
    iLoop = 1'b1;
    trig(2'd0);
    iLoop = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 1; exp_q.size() != 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (w_obs !== e) begin
          bad++;
          $display("FAIL loop ph%0d cyc%0d: got en=%b f=%0d b=%b d=%b n=%0d want en=%b f=%0d b=%b d=%b n=%0d",
                   phase, c, w_obs.en, w_obs.freq, w_obs.busy, w_obs.done, w_obs.note, e.en, e.freq, e.busy, e.done, e.note);
        end
        if (exp_q.size() != 0) begin @(posedge iClock); #1; end
      end
      if (phase == 0) begin
        push_idle(1'b0, 3);
        iStop = 1'b1;
        @(posedge iClock); #1;
        iStop = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    total  = 0;
    bad    = 0;
    iReset = 1'b0;
    iTrig  = 1'b0;
    iSel   = 2'd0;
    iStop  = 1'b0;
`ifdef SE_SEQ_LOOP_EN
    iLoop  = 1'b0;
`endif
    @(posedge iClock); #1;
    test_reset();
    test_effect0();
    test_rest_and_retrigger();
    test_trig_on_expiry();
    test_stop_with_trig();
    test_reset_mid_note();
    test_clamp_and_index_limit();
`ifdef SE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
